// File: rtl/sqrt_prenorm_pipelined_pkg.sv
// Shared sizing constants for the square-root pre-normalizer and its
// neighbours (sqrt_pipelined core, lzc_pair).
package sqrt_prenorm_pipelined_pkg;

  localparam int DEF_BITS       = 32;
  localparam int DEF_CORE_LAT   = 31;
  localparam int DEF_SHIFT_W    = $clog2(DEF_BITS);
  localparam int PRENORM_STAGES = 3;
  // The core samples x_norm one edge after stage 3 updates it.
  localparam int CORE_SAMPLE    = 1;

  function automatic int sb_depth(input int core_lat);
    return core_lat + CORE_SAMPLE;
  endfunction

  function automatic int inflight_max(input int core_lat);
    return PRENORM_STAGES + CORE_SAMPLE + core_lat;
  endfunction

  function automatic int inflight_w(input int core_lat);
    int w;
    w = $clog2(inflight_max(core_lat) + 1);
    return (w < 6) ? 6 : w;
  endfunction

  localparam int DEF_SB_DEPTH     = DEF_CORE_LAT + CORE_SAMPLE;
  localparam int DEF_INFLIGHT_MAX = PRENORM_STAGES + CORE_SAMPLE + DEF_CORE_LAT;

endpackage

// File: rtl/sqrt_prenorm_pipelined_lzc_pair.sv
// Combinational leading-zero counter returning lz (0..BITS) and the
// even-shift pair count k = floor(lz/2).
module lzc_pair
  import sqrt_prenorm_pipelined_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic [BITS-1:0]           data,
  output logic [$clog2(BITS+1)-1:0] lz,
  output logic [$clog2(BITS)-1:0]   k
);

  localparam int LZW = $clog2(BITS + 1);
  localparam int SW  = $clog2(BITS);

  logic found;

  always_comb begin
    lz    = LZW'(BITS);
    found = 1'b0;
    for (int i = BITS - 1; i >= 0; i--) begin
      if (!found && data[i]) begin
        lz    = LZW'(BITS - 1 - i);
        found = 1'b1;
      end
    end
    k = SW'(lz >> 1);
  end

endmodule

// File: rtl/sqrt_prenorm_pipelined.sv
// Three-stage operand normalizer in front of sqrt_pipelined, plus the
// {k, zero, valid} sideband delay line and in-flight token counter.
module sqrt_prenorm_pipelined
  import sqrt_prenorm_pipelined_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int CORE_LAT = DEF_CORE_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BITS-1:0]         x_in,
  input  logic                    x_vld,
  output logic [BITS-1:0]         x_norm,
  output logic                    norm_vld,
  output logic [$clog2(BITS)-1:0] sb_shift,
  output logic                    sb_zero,
  output logic                    sb_vld,
  output logic                    busy
);

  localparam int SW       = $clog2(BITS);
  localparam int LZW      = $clog2(BITS + 1);
  localparam int SB_DEPTH = sb_depth(CORE_LAT);
  localparam int CNT_W    = inflight_w(CORE_LAT);
  localparam int CNT_MAX  = inflight_max(CORE_LAT);

  // Stage 1: raw capture, data is never gated by valid.
  logic [BITS-1:0] s1_data_reg;
  logic            s1_vld_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_reg <= '0;
      s1_vld_reg  <= 1'b0;
    end else begin
      s1_data_reg <= x_in;
      s1_vld_reg  <= x_vld;
    end
  end

  // Stage 2: leading-zero count and even shift pairing.
  logic [LZW-1:0]  lz;
  logic [SW-1:0]   lz_k;
  logic [BITS-1:0] s2_data_reg;
  logic [SW-1:0]   s2_k_reg;
  logic            s2_zero_reg;
  logic            s2_vld_reg;

  lzc_pair #(
    .BITS(BITS)
  ) u_lzc (
    .data(s1_data_reg),
    .lz  (lz),
    .k   (lz_k)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_data_reg <= '0;
      s2_k_reg    <= '0;
      s2_zero_reg <= 1'b0;
      s2_vld_reg  <= 1'b0;
    end else begin
      s2_data_reg <= s1_data_reg;
      s2_k_reg    <= lz_k;
      s2_zero_reg <= (lz == LZW'(BITS));
      s2_vld_reg  <= s1_vld_reg;
    end
  end

  // Stage 3: shift by an even amount so the square root stays exact in k.
  logic [BITS-1:0] x_norm_next;
  logic [BITS-1:0] x_norm_reg;
  logic [SW-1:0]   s3_k_reg;
  logic            s3_zero_reg;
  logic            norm_vld_reg;

  always_comb begin
    x_norm_next = s2_data_reg << {s2_k_reg, 1'b0};
    if (s2_zero_reg) begin
      x_norm_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_norm_reg   <= '0;
      s3_k_reg     <= '0;
      s3_zero_reg  <= 1'b0;
      norm_vld_reg <= 1'b0;
    end else begin
      x_norm_reg   <= x_norm_next;
      s3_k_reg     <= s2_zero_reg ? '0 : s2_k_reg;
      s3_zero_reg  <= s2_zero_reg;
      norm_vld_reg <= s2_vld_reg;
    end
  end

  // Sideband line: element 0 mirrors the core's sampling edge, the last
  // element lines up with osqrt.
  logic [SW-1:0] sb_k_reg    [SB_DEPTH];
  logic          sb_zero_reg [SB_DEPTH];
  logic          sb_vld_reg  [SB_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_k_reg[i]    <= '0;
        sb_zero_reg[i] <= 1'b0;
        sb_vld_reg[i]  <= 1'b0;
      end
    end else begin
      sb_k_reg[0]    <= s3_k_reg;
      sb_zero_reg[0] <= s3_zero_reg;
      sb_vld_reg[0]  <= norm_vld_reg;
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb_k_reg[i]    <= sb_k_reg[i-1];
        sb_zero_reg[i] <= sb_zero_reg[i-1];
        sb_vld_reg[i]  <= sb_vld_reg[i-1];
      end
    end
  end

  // A token stays counted until the cycle its sb_vld is presented.
  logic [CNT_W-1:0] inflight_reg;
  logic [CNT_W-1:0] inflight_next;

  always_comb begin
    inflight_next = inflight_reg;
    if (x_vld && !sb_vld) begin
      inflight_next = inflight_reg + CNT_W'(1);
    end else if (sb_vld && !x_vld) begin
      inflight_next = inflight_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(x_vld && !sb_vld && (inflight_reg == CNT_W'(CNT_MAX))));

  assert property (@(posedge clk) disable iff (rst)
    !(sb_vld && !x_vld && (inflight_reg == '0)));

  assign x_norm   = x_norm_reg;
  assign norm_vld = norm_vld_reg;
  assign sb_shift = sb_k_reg[SB_DEPTH-1];
  assign sb_zero  = sb_zero_reg[SB_DEPTH-1];
  assign sb_vld   = sb_vld_reg[SB_DEPTH-1];
  assign busy     = (inflight_reg != '0);

endmodule

// File: tb/tb_sqrt_prenorm_pipelined.sv
// Directed/scoreboard bench for sqrt_prenorm_pipelined with a behavioural
// sqrt core delay model fed from x_norm.
module tb_sqrt_prenorm_pipelined;

  localparam int BITS     = 32;
  localparam int CORE_LAT = 31;
  localparam int SW       = 5;
  localparam int LAT_N    = 3;
  localparam int LAT_SB   = 4 + CORE_LAT;
  localparam int NCYC     = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   x_in;
  logic          x_vld;
  logic [31:0]   x_norm;
  logic          norm_vld;
  logic [SW-1:0] sb_shift;
  logic          sb_zero;
  logic          sb_vld;
  logic          busy;

  always #5 clk = ~clk;

  sqrt_prenorm_pipelined #(
    .BITS    (BITS),
    .CORE_LAT(CORE_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .x_in    (x_in),
    .x_vld   (x_vld),
    .x_norm  (x_norm),
    .norm_vld(norm_vld),
    .sb_shift(sb_shift),
    .sb_zero (sb_zero),
    .sb_vld  (sb_vld),
    .busy    (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] isqrt64(input logic [63:0] v);
    logic [31:0] r;
    logic [63:0] t;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = {32'd0, r | (32'd1 << b)};
      if (t * t <= v) r = t[31:0];
    end
    return r;
  endfunction

  // Reference normalization: shift left by two until one of the top two bits is set.
  task automatic ref_norm(input logic [31:0] x, output logic [31:0] n,
                          output logic [SW-1:0] k, output bit z);
    n = x;
    k = '0;
    z = (x == 32'd0);
    if (!z) begin
      while (n[31:30] == 2'b00) begin
        n = n << 2;
        k = k + 1'b1;
      end
    end
  endtask

  // Behavioural core: samples x_norm every edge, result CORE_LAT edges later.
  logic [31:0] core_pipe [CORE_LAT+1];
  always @(posedge clk) begin
    core_pipe[0] <= x_norm;
    for (int i = 1; i <= CORE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end

  bit            exp_nv  [NCYC];
  logic [31:0]   exp_xn  [NCYC];
  bit            exp_sv  [NCYC];
  logic [SW-1:0] exp_sh  [NCYC];
  bit            exp_z   [NCYC];
  logic [31:0]   exp_ref [NCYC];
  int            exp_cnt [NCYC];

  bit          mon_en  = 1'b0;
  int          peak    = 0;
  int          run     = 0;
  int          run_max = 0;
  int          mc;
  logic [31:0] root;

  always @(negedge clk) begin
    if (mon_en && cyc < NCYC) begin
      mc = cyc;
      check_eq("norm_vld", norm_vld, exp_nv[mc]);
      if (exp_nv[mc]) check_eq("x_norm", x_norm, exp_xn[mc]);
      check_eq("sb_vld", sb_vld, exp_sv[mc]);
      if (exp_sv[mc]) begin
        check_eq("sb_shift", sb_shift, exp_sh[mc]);
        check_eq("sb_zero", sb_zero, exp_z[mc]);
        if (!exp_z[mc]) begin
          root = isqrt64({1'b0, core_pipe[CORE_LAT], 31'd0}) >> sb_shift;
          check_eq("sqrt_2lsb", ((root + 32'd2 >= exp_ref[mc]) && (root <= exp_ref[mc] + 32'd2)), 1);
        end
      end
      check_eq("inflight", dut.inflight_reg, exp_cnt[mc]);
      check_eq("busy", busy, exp_cnt[mc] != 0);
      if (int'(dut.inflight_reg) > peak) peak = int'(dut.inflight_reg);
      run = sb_vld ? run + 1 : 0;
      if (run > run_max) run_max = run;
    end
  end

  // Called at a negedge; inputs are sampled at the following posedge.
  task automatic drive(input bit v, input logic [31:0] x, input logic [31:0] xn,
                       input logic [SW-1:0] sh, input bit z, input bit r);
    int d;
    d     = cyc;
    rst   = r;
    x_vld = v;
    x_in  = x;
    if (r) begin
      for (int c = d + 1; c < NCYC; c++) begin
        exp_nv[c]  = 1'b0;
        exp_sv[c]  = 1'b0;
        exp_cnt[c] = 0;
      end
    end else if (v) begin
      exp_nv[d+LAT_N]   = 1'b1;
      exp_xn[d+LAT_N]   = xn;
      exp_sv[d+LAT_SB]  = 1'b1;
      exp_sh[d+LAT_SB]  = sh;
      exp_z[d+LAT_SB]   = z;
      exp_ref[d+LAT_SB] = isqrt64({1'b0, x, 31'd0});
      for (int c = d + 1; c <= d + LAT_SB; c++) exp_cnt[c]++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, '0, 1'b0, 1'b0);
  endtask

  task automatic send_rand(input bit r);
    logic [31:0]   x;
    logic [31:0]   n;
    logic [SW-1:0] k;
    bit            z;
    x = $urandom() >> $urandom_range(0, 31);
    ref_norm(x, n, k, z);
    drive(1'b1, x, n, k, z, r);
  endtask

  logic [31:0]   dir_x  [8] = '{32'h0000_0001, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000,
                                32'h4000_0000, 32'h2000_0000, 32'hFFFF_FFFF, 32'h0000_0003};
  logic [31:0]   dir_xn [8] = '{32'h4000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000,
                                32'h4000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hC000_0000};
  logic [SW-1:0] dir_sh [8] = '{5'd15, 5'd0, 5'd7, 5'd0, 5'd0, 5'd1, 5'd0, 5'd15};
  bit            dir_z  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst   = 1'b1;
    x_vld = 1'b0;
    x_in  = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_x_norm", x_norm, 0);
    check_eq("rst_sb_shift", sb_shift, 0);
    check_eq("rst_sb_zero", sb_zero, 0);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, dir_x[i], dir_xn[i], dir_sh[i], dir_z[i], 1'b0);
      idle(2);
    end
    idle(40);

    for (int i = 0; i < 40; i++) send_rand(1'b0);
    idle(40);

    // 20-token stream with reset on the 10th slot, x_vld held high during it.
    for (int i = 0; i < 20; i++) begin
      if (i == 9) begin
        drive(1'b1, 32'h0000_0100, 32'd0, '0, 1'b0, 1'b1);
        check_eq("mid_rst_x_norm", x_norm, 0);
        check_eq("mid_rst_sb_shift", sb_shift, 0);
      end else begin
        send_rand(1'b0);
      end
    end
    idle(40);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) send_rand(1'b0);
      else idle(1);
    end
    idle(45);

    check_eq("inflight_peak", peak, 35);
    check_eq("sb_vld_run", run_max, 40);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
